// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SB_SPI flash read sequencer.
package spi_flash_pkg;

    localparam logic [7:0] SB_CR1  = 8'h09;
    localparam logic [7:0] SB_CR2  = 8'h0A;
    localparam logic [7:0] SB_BR   = 8'h0B;
    localparam logic [7:0] SB_SR   = 8'h0C;
    localparam logic [7:0] SB_TXDR = 8'h0D;
    localparam logic [7:0] SB_RXDR = 8'h0E;
    localparam logic [7:0] SB_CSR  = 8'h0F;

    localparam int SR_TIP  = 7;
    localparam int SR_TRDY = 4;
    localparam int SR_RRDY = 3;

    localparam logic [7:0] CR1_EN   = 8'h80;
    localparam logic [7:0] CR2_MSTR = 8'hC0;
    localparam logic [7:0] CSR_NONE = 8'h00;
    localparam logic [7:0] CSR_CS0  = 8'h01;

    localparam logic [7:0] FLASH_READ = 8'h03;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_TXW, S_TXD, S_RXW, S_RXD, S_PUSH, S_FIN, S_REL, S_DONE
    } seq_state_e;

endpackage

// File: rtl/spi_sb_access.sv
// Single-access SB master: latches one request, holds strobe until ack.
module spi_sb_access (
    input  logic       clk_24m,
    input  logic       rst,
    input  logic       req_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic       rw_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic [7:0] sb_addr_o,
    output logic [7:0] sb_di_o,
    output logic       sb_rw_o,
    output logic       sb_stb_o,
    input  logic [7:0] sb_do_i,
    input  logic       sb_ack_i
);

    logic       stb_q, stb_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] di_q, di_d;
    logic       rw_q, rw_d;
    logic [7:0] rdata_q, rdata_d;

    always_comb begin
        stb_d   = stb_q;
        addr_d  = addr_q;
        di_d    = di_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        if (stb_q) begin
            if (sb_ack_i) begin
                stb_d   = 1'b0;
                rdata_d = sb_do_i;
            end
        end else if (req_i) begin
            stb_d  = 1'b1;
            addr_d = addr_i;
            di_d   = wdata_i;
            rw_d   = rw_i;
        end
    end

    always_ff @(posedge clk_24m or posedge rst) begin
        if (rst) begin
            stb_q   <= 1'b0;
            addr_q  <= 8'h00;
            di_q    <= 8'h00;
            rw_q    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy_o    = stb_q;
    assign done_o    = stb_q & sb_ack_i;
    // Bypass so callers can use the read data in the ack cycle itself.
    assign rdata_o   = done_o ? sb_do_i : rdata_q;
    assign sb_addr_o = addr_q;
    assign sb_di_o   = di_q;
    assign sb_rw_o   = rw_q;
    assign sb_stb_o  = stb_q;

endmodule

// File: rtl/spi_flash_seq.sv
// Flash READ sequencer for SB_SPI, sharing the SB bus with CPU Wishbone accesses.
module spi_flash_seq
    import spi_flash_pkg::*;
#(
    parameter int         LEN_W   = 16,
    parameter logic [7:0] SPI_DIV = 8'h00
) (
    input  logic             clk_24m,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic [23:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_busy,
    output logic             cmd_done,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [3:0]       wb_addr,
    input  logic [7:0]       wb_wdata,
    output logic [7:0]       wb_rdata,
    input  logic             wb_we,
    input  logic             wb_cyc,
    output logic             wb_ack,
    output logic [7:0]       sb_addr,
    output logic [7:0]       sb_di,
    input  logic [7:0]       sb_do,
    output logic             sb_rw,
    output logic             sb_stb,
    input  logic             sb_ack
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    seq_state_e       state_q, state_d;
    logic [2:0]       cfg_idx_q, cfg_idx_d;
    logic [2:0]       hdr_q, hdr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [23:0]      addr_q, addr_d;
    logic [7:0]       odata_q, odata_d;
    logic             ovld_q, ovld_d;
    logic             owner_cpu_q, owner_cpu_d;

    logic       fsm_req, fsm_rw, fsm_done;
    logic [7:0] fsm_addr, fsm_wdata;
    logic       cpu_sel, acc_req, acc_rw;
    logic [7:0] acc_addr, acc_wdata;
    logic       eng_busy, eng_done;
    logic [7:0] eng_rdata;

    // An in-flight access stays with its owner; otherwise the CPU wins only in IDLE.
    assign cpu_sel     = eng_busy ? owner_cpu_q : (state_q == S_IDLE);
    assign acc_req     = cpu_sel ? wb_cyc : fsm_req;
    assign acc_addr    = cpu_sel ? {4'h0, wb_addr} : fsm_addr;
    assign acc_wdata   = cpu_sel ? wb_wdata : fsm_wdata;
    assign acc_rw      = cpu_sel ? wb_we : fsm_rw;
    assign owner_cpu_d = (!eng_busy && acc_req) ? cpu_sel : owner_cpu_q;
    assign fsm_done    = eng_done & ~owner_cpu_q;
    assign wb_ack      = eng_done & owner_cpu_q;
    assign wb_rdata    = eng_rdata;

    spi_sb_access u_acc (
        .clk_24m  (clk_24m),
        .rst      (rst),
        .req_i    (acc_req),
        .addr_i   (acc_addr),
        .wdata_i  (acc_wdata),
        .rw_i     (acc_rw),
        .busy_o   (eng_busy),
        .done_o   (eng_done),
        .rdata_o  (eng_rdata),
        .sb_addr_o(sb_addr),
        .sb_di_o  (sb_di),
        .sb_rw_o  (sb_rw),
        .sb_stb_o (sb_stb),
        .sb_do_i  (sb_do),
        .sb_ack_i (sb_ack)
    );

    always_comb begin
        state_d   = state_q;
        cfg_idx_d = cfg_idx_q;
        hdr_d     = hdr_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        odata_d   = odata_q;
        ovld_d    = ovld_q;
        fsm_req   = 1'b0;
        fsm_rw    = 1'b0;
        fsm_addr  = SB_SR;
        fsm_wdata = 8'h00;
        if (ovld_q && out_ready) ovld_d = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_start) begin
                addr_d    = cmd_addr;
                rem_d     = cmd_len;
                cfg_idx_d = 3'd0;
                hdr_d     = 3'd4;
                state_d   = S_CFG;
            end
            S_CFG: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    fsm_req = 1'b1;
                    fsm_rw  = 1'b1;
                    case (cfg_idx_q)
                        3'd0:    begin fsm_addr = SB_CSR; fsm_wdata = CSR_NONE; end
                        3'd1:    begin fsm_addr = SB_CR1; fsm_wdata = CR1_EN;   end
                        3'd2:    begin fsm_addr = SB_CR2; fsm_wdata = CR2_MSTR; end
                        3'd3:    begin fsm_addr = SB_BR;  fsm_wdata = SPI_DIV;  end
                        default: begin fsm_addr = SB_CSR; fsm_wdata = CSR_CS0;  end
                    endcase
                    if (fsm_done) begin
                        if (cfg_idx_q == 3'd4) state_d = S_TXW;
                        else                   cfg_idx_d = cfg_idx_q + 3'd1;
                    end
                end
            end
            S_TXW: begin
                fsm_req = 1'b1;
                if (fsm_done && eng_rdata[SR_TRDY]) state_d = S_TXD;
            end
            S_TXD: begin
                // A pending output byte stalls the next shift, which also idles SCK.
                fsm_req  = ~(ovld_q & ~out_ready);
                fsm_rw   = 1'b1;
                fsm_addr = SB_TXDR;
                case (hdr_q)
                    3'd4:    fsm_wdata = FLASH_READ;
                    3'd3:    fsm_wdata = addr_q[23:16];
                    3'd2:    fsm_wdata = addr_q[15:8];
                    3'd1:    fsm_wdata = addr_q[7:0];
                    default: fsm_wdata = 8'h00;
                endcase
                if (fsm_done) state_d = S_RXW;
            end
            S_RXW: begin
                fsm_req = 1'b1;
                if (fsm_done && eng_rdata[SR_RRDY]) state_d = S_RXD;
            end
            S_RXD: begin
                fsm_req  = 1'b1;
                fsm_addr = SB_RXDR;
                if (fsm_done) begin
                    if (hdr_q != 3'd0) begin
                        hdr_d   = hdr_q - 3'd1;
                        state_d = S_TXW;
                    end else begin
                        odata_d = eng_rdata;
                        ovld_d  = 1'b1;
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                rem_d   = rem_q - LEN_ONE;
                state_d = (rem_q == LEN_ONE) ? S_FIN : S_TXW;
            end
            S_FIN: begin
                fsm_req = 1'b1;
                if (fsm_done && !eng_rdata[SR_TIP]) state_d = S_REL;
            end
            S_REL: begin
                fsm_req   = 1'b1;
                fsm_rw    = 1'b1;
                fsm_addr  = SB_CSR;
                fsm_wdata = CSR_NONE;
                if (fsm_done) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_24m or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cfg_idx_q   <= 3'd0;
            hdr_q       <= 3'd0;
            rem_q       <= '0;
            addr_q      <= 24'h0;
            odata_q     <= 8'h00;
            ovld_q      <= 1'b0;
            owner_cpu_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_idx_q   <= cfg_idx_d;
            hdr_q       <= hdr_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            odata_q     <= odata_d;
            ovld_q      <= ovld_d;
            owner_cpu_q <= owner_cpu_d;
        end
    end

    assign cmd_busy  = (state_q != S_IDLE);
    assign cmd_done  = (state_q == S_DONE);
    assign out_data  = odata_q;
    assign out_valid = ovld_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Bench for spi_flash_seq: behavioural SB_SPI model plus expected-transaction reference.
module tb_spi_flash_seq;

    localparam logic [7:0] DIV = 8'h05;

    logic        clk_24m = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cmd_busy, cmd_done;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;
    logic [3:0]  wb_addr;
    logic [7:0]  wb_wdata, wb_rdata;
    logic        wb_we, wb_cyc, wb_ack;
    logic [7:0]  sb_addr, sb_di, sb_do;
    logic        sb_rw, sb_stb, sb_ack;

    int n_asrt = 0;
    int n_fail = 0;

    logic [7:0]  regs [16];
    int          lat_cnt = 0, trdy_stall = 0, rx_n = 0, bad_txdr = 0;
    int          stb_rises = 0, gap_err = 0, done_cnt = 0;
    logic        ack_prev = 1'b0, stb_prev = 1'b0;
    logic [15:0] wr_q [$];
    logic [8:0]  acc_q [$];
    logic [7:0]  got_q [$];

    always #20 clk_24m = ~clk_24m;

    spi_flash_seq #(.LEN_W(16), .SPI_DIV(DIV)) dut (
        .clk_24m(clk_24m), .rst(rst),
        .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .sb_addr(sb_addr), .sb_di(sb_di), .sb_do(sb_do),
        .sb_rw(sb_rw), .sb_stb(sb_stb), .sb_ack(sb_ack)
    );

    // SB_SPI model: acks each strobe after 0-2 wait cycles; SR=0x18 unless TRDY is being withheld.
    initial forever begin
        @(posedge clk_24m or posedge rst);
        if (rst) begin
            sb_ack <= 1'b0;
            sb_do  <= 8'h00;
            lat_cnt = 0;
        end else if (sb_ack) begin
            sb_ack <= 1'b0;
        end else if (sb_stb) begin
            if (lat_cnt > 0) lat_cnt--;
            else begin
                lat_cnt = int'($urandom_range(0, 2));
                sb_ack <= 1'b1;
                acc_q.push_back({sb_rw, sb_addr});
                if (sb_rw) begin
                    wr_q.push_back({sb_addr, sb_di});
                    if (sb_addr == 8'h0D && trdy_stall != 0) bad_txdr++;
                    regs[sb_addr[3:0]] = sb_di;
                end else begin
                    case (sb_addr)
                        8'h0C: begin
                            if (trdy_stall > 0) begin trdy_stall--; sb_do <= 8'h08; end
                            else sb_do <= 8'h18;
                        end
                        8'h0E: begin sb_do <= 8'hA0 + 8'(rx_n); rx_n++; end
                        default: sb_do <= regs[sb_addr[3:0]];
                    endcase
                end
            end
        end
    end

    initial forever begin
        @(posedge clk_24m);
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (cmd_done) done_cnt++;
        if (sb_stb && !stb_prev) stb_rises++;
        if (ack_prev && sb_stb) gap_err++;
        ack_prev = sb_ack;
        stb_prev = sb_stb;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_q.delete(); acc_q.delete(); got_q.delete();
        rx_n = 0; done_cnt = 0; bad_txdr = 0;
    endtask

    task automatic start_cmd(input logic [23:0] a, input int len);
        @(negedge clk_24m);
        cmd_addr  = a;
        cmd_len   = 16'(len);
        cmd_start = 1'b1;
        @(negedge clk_24m);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input bit rand_rdy, input string tag);
        int n = 0;
        while (!cmd_done && n < 5000) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk_24m);
            n++;
        end
        chk({tag, " done seen"}, 32'(cmd_done), 32'd1);
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 100) begin @(negedge clk_24m); n++; end
        @(negedge clk_24m);
    endtask

    // Reference: the register writes and output bytes a READ of len bytes at a must produce.
    task automatic check_cmd(input logic [23:0] a, input int len, input string tag);
        logic [15:0] exp_q [$];
        if (len != 0) begin
            exp_q.push_back(16'h0F00); exp_q.push_back(16'h0980);
            exp_q.push_back(16'h0AC0); exp_q.push_back({8'h0B, DIV});
            exp_q.push_back(16'h0F01); exp_q.push_back(16'h0D03);
            exp_q.push_back({8'h0D, a[23:16]}); exp_q.push_back({8'h0D, a[15:8]});
            exp_q.push_back({8'h0D, a[7:0]});
            for (int i = 0; i < len; i++) exp_q.push_back(16'h0D00);
            exp_q.push_back(16'h0F00);
        end
        chk({tag, " write count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk($sformatf("%s write %0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
        chk({tag, " byte count"}, 32'(got_q.size()), 32'(len));
        for (int i = 0; i < len && i < got_q.size(); i++)
            chk($sformatf("%s byte %0d", tag, i), 32'(got_q[i]), 32'(8'hA4 + 8'(i)));
        chk({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, " idle after"}, 32'(cmd_busy), 32'd0);
    endtask

    initial begin
        int n, s0, w0, w1;
        logic [7:0]  d0;
        logic [23:0] ra;
        int          rl;
        rst = 1'b1; cmd_start = 1'b0; cmd_addr = 24'h0; cmd_len = 16'h0; out_ready = 1'b1;
        wb_addr = 4'h0; wb_wdata = 8'h00; wb_we = 1'b0; wb_cyc = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        repeat (3) @(negedge clk_24m);
        chk("rst sb_stb", 32'(sb_stb), 32'd0);
        chk("rst wb_ack", 32'(wb_ack), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst cmd_busy", 32'(cmd_busy), 32'd0);
        chk("rst cmd_done", 32'(cmd_done), 32'd0);
        chk("rst sb_addr", 32'(sb_addr), 32'd0);
        chk("rst sb_di", 32'(sb_di), 32'd0);
        rst = 1'b0;
        @(negedge clk_24m);

        clear_logs();
        start_cmd(24'h123456, 3);
        chk("basic busy after accept", 32'(cmd_busy), 32'd1);
        wait_done(1'b0, "basic");
        check_cmd(24'h123456, 3, "basic");

        clear_logs();
        start_cmd(24'hABCDEF, 3);
        n = 0;
        while (!(got_q.size() == 1 && out_valid) && n < 5000) begin @(negedge clk_24m); n++; end
        chk("bp second byte presented", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        d0 = out_data;
        w0 = 0;
        foreach (wr_q[i]) if (wr_q[i][15:8] == 8'h0D) w0++;
        repeat (10) begin
            @(negedge clk_24m);
            chk("bp valid held", 32'(out_valid), 32'd1);
            chk("bp data stable", 32'(out_data), 32'(d0));
        end
        w1 = 0;
        foreach (wr_q[i]) if (wr_q[i][15:8] == 8'h0D) w1++;
        chk("bp no txdr during stall", 32'(w1), 32'(w0));
        out_ready = 1'b1;
        wait_done(1'b0, "bp");
        check_cmd(24'hABCDEF, 3, "bp");

        clear_logs();
        @(negedge clk_24m);
        cmd_addr = 24'h0A0B0C; cmd_len = 16'd2; cmd_start = 1'b1;
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 4'hC;
        @(negedge clk_24m);
        cmd_start = 1'b0;
        n = 0;
        while (!wb_ack && n < 200) begin @(negedge clk_24m); n++; end
        chk("arb cpu ack", 32'(wb_ack), 32'd1);
        chk("arb cpu rdata SR", 32'(wb_rdata), 32'h18);
        chk("arb cpu access first", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) chk("arb first access SR read", 32'(acc_q[0]), 32'h00C);
        wb_cyc = 1'b0;
        repeat (6) @(negedge clk_24m);
        chk("arb busy before cpu", 32'(cmd_busy), 32'd1);
        wb_addr = 4'hB; wb_cyc = 1'b1;
        n = 0;
        while (!wb_ack && n < 5000) begin @(negedge clk_24m); n++; end
        chk("arb busy cpu ack", 32'(wb_ack), 32'd1);
        chk("arb cpu ack after done", 32'(done_cnt), 32'd1);
        chk("arb cpu rdata BR", 32'(wb_rdata), 32'(DIV));
        wb_cyc = 1'b0;
        repeat (2) @(negedge clk_24m);
        check_cmd(24'h0A0B0C, 2, "arb");

        clear_logs();
        s0 = stb_rises;
        start_cmd(24'h000100, 0);
        chk("zero busy", 32'(cmd_busy), 32'd1);
        chk("zero done not early", 32'(cmd_done), 32'd0);
        @(negedge clk_24m);
        chk("zero done at +2", 32'(cmd_done), 32'd1);
        repeat (3) @(negedge clk_24m);
        chk("zero no strobe", 32'(stb_rises), 32'(s0));
        check_cmd(24'h000100, 0, "zero");

        clear_logs();
        trdy_stall = 20;
        start_cmd(24'h00FF00, 1);
        wait_done(1'b0, "stall");
        chk("stall txdr before trdy", 32'(bad_txdr), 32'd0);
        chk("stall polls consumed", 32'(trdy_stall), 32'd0);
        check_cmd(24'h00FF00, 1, "stall");

        clear_logs();
        start_cmd(24'h654321, 4);
        n = 0;
        while (!(sb_stb && sb_rw && sb_addr == 8'h0D) && n < 5000) begin @(negedge clk_24m); n++; end
        chk("rstmid in txd", 32'(sb_stb && sb_addr == 8'h0D), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid sb_stb", 32'(sb_stb), 32'd0);
        chk("rstmid idle", 32'(cmd_busy), 32'd0);
        chk("rstmid out_valid", 32'(out_valid), 32'd0);
        @(negedge clk_24m);
        rst = 1'b0;
        @(negedge clk_24m);
        clear_logs();
        start_cmd(24'h000010, 2);
        wait_done(1'b0, "rstmid");
        if (acc_q.size() > 0) chk("rstmid first access CSR write", 32'(acc_q[0]), 32'h10F);
        check_cmd(24'h000010, 2, "rstmid");

        for (int k = 0; k < 4; k++) begin
            ra = 24'($urandom);
            rl = int'($urandom_range(1, 6));
            clear_logs();
            start_cmd(ra, rl);
            wait_done(1'b1, $sformatf("rand%0d", k));
            check_cmd(ra, rl, $sformatf("rand%0d", k));
        end

        chk("stb idle gap after ack", 32'(gap_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
